result_drain_serializer: RTL and testbench

- Sits downstream of the vector-multiply top level and drains the results SRAM after a compute pass.
- Reads rows of MATRIX_SIZE signed partial sums (PARTIAL_SUM_BW each).
- Streams the partial sums one lane per beat over a narrow valid/ready output port for host readout.
- Owns results-SRAM read addressing and signals busy/done to the control state machine.

---
 rtl/result_drain_serializer_pkg.sv | 18 +
 rtl/result_drain_serializer_lane_mux_row_buffer.sv | 31 +++
 rtl/result_drain_serializer.sv | 111 +++++++++++
 tb/tb_result_drain_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_drain_serializer_pkg.sv
// Shared definitions for the results-SRAM drain serializer: default sizes and FSM encoding.
package result_drain_serializer_pkg;

    localparam int DEF_ADDRESSSIZE    = 10;
    localparam int DEF_MATRIX_SIZE    = 64;
    localparam int DEF_PARTIAL_SUM_BW = 24;
    localparam int DEF_LANE_IDX_BW    = 6;
    localparam int DEF_ROW_BW         = DEF_PARTIAL_SUM_BW * DEF_MATRIX_SIZE;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_ISSUE  = 3'd1;
    localparam state_t S_WAIT   = 3'd2;
    localparam state_t S_STREAM = 3'd3;
    localparam state_t S_FINISH = 3'd4;

endpackage

// File: rtl/result_drain_serializer_lane_mux_row_buffer.sv
// Holds one full results row and selects a single lane of it for the narrow output port.
module lane_mux_row_buffer
    import result_drain_serializer_pkg::*;
#(
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int LANE_IDX_BW    = DEF_LANE_IDX_BW
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  load,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_data,
    input  logic [LANE_IDX_BW-1:0]                lane_sel,
    output logic [PARTIAL_SUM_BW-1:0]             lane_data
);

    localparam int ROW_BW = PARTIAL_SUM_BW * MATRIX_SIZE;

    logic [ROW_BW-1:0] row_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            row_q <= '0;
        else if (load)
            row_q <= row_data;
    end

    // Lane 0 sits in the least significant bits of the row.
    assign lane_data = row_q[lane_sel*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];

endmodule

// File: rtl/result_drain_serializer.sv
// Drains consecutive results-SRAM rows and streams them one signed lane per beat over valid/ready.
module result_drain_serializer
    import result_drain_serializer_pkg::*;
#(
    parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE,
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int LANE_IDX_BW    = DEF_LANE_IDX_BW
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [ADDRESSSIZE:0]                  num_rows,
    output logic                                  sram_rd_en,
    output logic [ADDRESSSIZE-1:0]                sram_rd_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rd_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [PARTIAL_SUM_BW-1:0]             out_data,
    output logic [LANE_IDX_BW-1:0]                out_lane,
    output logic [ADDRESSSIZE-1:0]                out_row,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done
);

    state_t                 state;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [ADDRESSSIZE:0]   rows_q;
    logic [ADDRESSSIZE:0]   row_cnt;
    logic [ADDRESSSIZE:0]   row_nxt;
    logic [LANE_IDX_BW-1:0] lane_cnt;
    logic [ADDRESSSIZE-1:0] cur_addr;
    logic                   last_lane;
    logic                   last_row;
    logic                   handshake;

    // row_cnt is one bit wider than the address so a full 2^ADDRESSSIZE drain can be counted;
    // the address itself wraps silently.
    assign row_nxt   = row_cnt + 1'b1;
    assign last_row  = (row_nxt == rows_q);
    assign last_lane = (lane_cnt == LANE_IDX_BW'(MATRIX_SIZE - 1));
    assign cur_addr  = base_q + row_cnt[ADDRESSSIZE-1:0];
    assign handshake = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            base_q   <= '0;
            rows_q   <= '0;
            row_cnt  <= '0;
            lane_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        rows_q   <= num_rows;
                        row_cnt  <= '0;
                        lane_cnt <= '0;
                        state    <= (num_rows == '0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    lane_cnt <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (handshake) begin
                        if (!last_lane) begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end else if (!last_row) begin
                            row_cnt <= row_nxt;
                            state   <= S_ISSUE;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after the strobe, which is exactly the WAIT cycle.
    lane_mux_row_buffer #(
        .MATRIX_SIZE    (MATRIX_SIZE),
        .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
        .LANE_IDX_BW    (LANE_IDX_BW)
    ) u_row_buf (
        .clk       (clk),
        .rstn      (rstn),
        .load      (state == S_WAIT),
        .row_data  (sram_rd_data),
        .lane_sel  (lane_cnt),
        .lane_data (out_data)
    );

    assign sram_rd_en   = (state == S_ISSUE);
    assign sram_rd_addr = cur_addr;
    assign out_valid    = (state == S_STREAM);
    assign out_lane     = lane_cnt;
    assign out_row      = cur_addr;
    assign out_last     = out_valid & last_lane & last_row;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_FINISH);

endmodule

// File: tb/tb_result_drain_serializer.sv
// Scoreboard bench for result_drain_serializer: stimulus pushes expected reads/beats, a monitor checks them.
module tb_result_drain_serializer;

    localparam int AS = 10;
    localparam int MS = 64;
    localparam int PB = 24;
    localparam int LB = 6;

    typedef struct packed {
        logic [PB-1:0] data;
        logic [LB-1:0] lane;
        logic [AS-1:0] row;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [AS-1:0]    base_addr = '0;
    logic [AS:0]      num_rows = '0;
    logic             sram_rd_en;
    logic [AS-1:0]    sram_rd_addr;
    logic [PB*MS-1:0] sram_rd_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [PB-1:0]    out_data;
    logic [LB-1:0]    out_lane;
    logic [AS-1:0]    out_row;
    logic             out_last;
    logic             busy;
    logic             done;

    int chk_cnt = 0;
    int pass_cnt = 0;

    beat_t         beat_q[$];
    logic [AS-1:0] addr_q[$];
    bit            bp = 1'b0;
    logic [3:0]    pat = 4'b1001;

    result_drain_serializer #(
        .ADDRESSSIZE(AS), .MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PB), .LANE_IDX_BW(LB)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
        .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Row 5 holds i-32 per lane; other rows are offset by (addr-5)*4096 so rows are distinguishable.
    function automatic logic [PB-1:0] lane_val(input logic [AS-1:0] a, input int i);
        int v;
        v = (i - 32) + (int'(a) - 5) * 4096;
        return v[PB-1:0];
    endfunction

    // SRAM model: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < MS; i++)
            sram_rd_data[i*PB +: PB] <= sram_rd_en ? lane_val(sram_rd_addr, i) : 24'hA5A5A5;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Backpressure driver: 1-0-0-1 ready pattern when enabled.
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? pat[k % 4] : 1'b1;
            k++;
        end
    end

    // Monitor
    beat_t cur, held_v, exp_b;
    bit    held = 0, seen = 0;
    int    gap = 0, dphase = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                held = 0; seen = 0; gap = 0; dphase = 0;
            end else begin
                cur = {out_data, out_lane, out_row, out_last};
                if (sram_rd_en) begin
                    check("rd_pending", 64'(addr_q.size() != 0), 64'd1);
                    if (addr_q.size() != 0) check("rd_addr", 64'(sram_rd_addr), 64'(addr_q.pop_front()));
                end
                if (dphase == 1) begin
                    check("done_pulse", {done, busy}, 2'b11);
                    dphase = 2;
                end else if (dphase == 2) begin
                    check("busy_fall", {done, busy}, 2'b00);
                    dphase = 0;
                end
                if (held && out_valid) check("stall_hold", 64'(cur), 64'(held_v));
                held   = out_valid && !out_ready;
                held_v = cur;
                if (!busy) begin
                    seen = 0; gap = 0;
                end else if (out_valid) begin
                    if (seen && gap != 0) check("bubbles", 64'(gap), 64'd2);
                    seen = 1; gap = 0;
                end else if (seen) begin
                    gap++;
                end
                if (out_valid && out_ready) begin
                    check("beat_pending", 64'(beat_q.size() != 0), 64'd1);
                    if (beat_q.size() != 0) begin
                        exp_b = beat_q.pop_front();
                        check("beat", 64'(cur), 64'(exp_b));
                    end
                    if (out_last) dphase = 1;
                end
            end
        end
    end

    task automatic push_drain(input logic [AS-1:0] base, input int n);
        logic [AS-1:0] a;
        for (int r = 0; r < n; r++) begin
            a = base + AS'(r);
            addr_q.push_back(a);
            for (int l = 0; l < MS; l++)
                beat_q.push_back(beat_t'({lane_val(a, l), LB'(l), a, (r == n - 1 && l == MS - 1)}));
        end
    endtask

    task automatic run_drain(input logic [AS-1:0] base, input int n,
                             input bit mid_start, input bit done_start);
        int cyc = 0;
        int first = -1;
        int bound = n * MS * 4 + 40;
        push_drain(base, n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_rows = (AS+1)'(n);
        forever begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; base_addr = 10'd777; num_rows = 11'd9;
            if (out_valid && first < 0) first = cyc;
            if (!busy) break;
            if (cyc > bound) begin
                check("drain_timeout", 64'(cyc), 64'(bound));
                break;
            end
            if (mid_start && cyc == 20) begin
                start = 1'b1; base_addr = 10'd300; num_rows = 11'd5;
            end
            if (done_start && done) begin
                start = 1'b1; base_addr = 10'd400; num_rows = 11'd2;
            end
        end
        if (n > 0) check("latency", 64'(first), 64'd3);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after", {busy, out_valid, sram_rd_en}, 3'b000);
        check("queues_empty", 64'(beat_q.size() + addr_q.size()), 64'd0);
    endtask

    initial begin
        bit found;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {sram_rd_en, out_valid, out_last, busy, done}, 5'b0);
        check("rst_data", {sram_rd_addr, out_data, out_lane, out_row}, 50'b0);
        rstn = 1'b1;

        // single row, ready tied high
        run_drain(10'd5, 1, 0, 0);
        // multi-row with backpressure
        bp = 1'b1;
        run_drain(10'd20, 3, 0, 0);
        bp = 1'b0;

        // zero rows
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd9; num_rows = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done", {done, busy, out_valid, sram_rd_en}, 4'b1100);
        @(posedge clk); #1;
        check("zero_after", {done, busy}, 2'b00);

        // address wrap
        run_drain(10'd1022, 4, 0, 0);
        // start while busy and start coincident with done
        run_drain(10'd100, 2, 1, 1);

        // reset mid-stream at lane 20 of row 1
        push_drain(10'd200, 3);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd200; num_rows = 11'd3;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (out_valid && out_lane == 6'd20 && out_row == 10'd201) begin
                found = 1;
                break;
            end
        end
        check("reset_reach", 64'(found), 64'd1);
        rstn = 1'b0;
        #1;
        check("reset_outs", {sram_rd_en, sram_rd_addr, out_valid, out_data, out_lane,
                             out_row, out_last, busy, done}, 55'b0);
        beat_q.delete();
        addr_q.delete();
        repeat (4) @(posedge clk);
        #1;
        check("reset_quiet", {done, busy, sram_rd_en, out_valid}, 4'b0);
        rstn = 1'b1;
        run_drain(10'd50, 1, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
